mmu_skew_feeder: RTL and testbench
==================================

// Module: mmu_skew_feeder
// PURPOSE
//   Input-side driver for the 4x4 systolic MMU. Accepts one K-step operand beat per handshake
//   (N activations + N weights), buffers up to MAX_K beats, and replays them diagonally skewed.
//   Lane i is delayed i cycles, so the MMU data/weight wavefronts align. Also sequences the
//   MMU accumulator clear, control enable and drain window, then pulses done.
// PARAMETERS
//   N            4   array dimension (lanes)
//   BIT_WIDTH    8   operand width per lane
//   MAX_K        16  max beats buffered per tile (power of 2)
//   DRAIN_CYCLES 8   cycles control stays high after last skewed beat (>=2*N)
// PORTS
//   clk       in   1             clock
//   reset     in   1             synchronous, active-high
//   in_valid  in   1             beat valid
//   in_ready  out  1             beat accepted when in_valid&&in_ready
//   in_data   in   N*BIT_WIDTH   activations, lane i = [i*BIT_WIDTH +: BIT_WIDTH]
//   in_wt     in   N*BIT_WIDTH   weights, same lane packing
//   in_last   in   1             marks final beat of tile
//   data_arr  out  N*BIT_WIDTH   skewed activations to MMU
//   wt_arr    out  N*BIT_WIDTH   skewed weights to MMU
//   mmu_ctl   out  1             MMU control/enable
//   mmu_clr   out  1             MMU accumulator clear (drives MMU reset)
//   busy      out  1             high in any state but LOAD
//   done      out  1             one-cycle pulse, tile finished
//   k_len     out  $clog2(MAX_K)+1  beats in current tile, valid CLEAR..DONE
// BEHAVIOUR
//   Reset: state=LOAD, k_cnt=0, t_cnt=0; in_ready=1. All other outputs 0, incl. data_arr/wt_arr.
//   FSM LOAD->CLEAR->STREAM->DRAIN->DONE->LOAD. All outputs registered (flop-driven).
//   LOAD: in_ready=1; accepted beat written to buf[k_cnt], k_cnt++.
//     Beat with in_last, or the MAX_K-th beat (k_cnt==MAX_K-1): k_len<=k_cnt+1, go to CLEAR.
//     Implicit last on MAX_K: beat is kept, no error flag. mmu_ctl=0, outputs 0.
//   CLEAR: exactly 1 cycle; mmu_clr=1, mmu_ctl=0, in_ready=0, data_arr/wt_arr=0; t_cnt<=0.
//   STREAM: K+N-1 cycles, t_cnt = 0..K+N-2, K = k_len; mmu_ctl=1, in_ready=0.
//     Each lane i: if 0<=t_cnt-i<K, output buf[t_cnt-i] lane i (data and wt); else 0.
//     Outputs reflect t_cnt in the same cycle; no extra pipeline stage vs. mmu_ctl.
//   DRAIN: DRAIN_CYCLES cycles; mmu_ctl=1, data_arr/wt_arr=0, in_ready=0.
//   DONE: 1 cycle; done=1, mmu_ctl=0. Then LOAD with k_cnt=0; buffer need not be cleared.
//   in_valid while busy: ignored, no acceptance (in_ready=0). Producer must hold the beat.
//   K=1 (first beat has in_last): STREAM lasts N cycles, lane i nonzero only at t_cnt=i.
//   Reset mid-tile (any state): aborts immediately to reset values; partial tile discarded.
//   Widths: t_cnt and k_len sized to hold MAX_K+N-1 and MAX_K; counters never wrap in
//   legal use. Operands pass through unmodified; no arithmetic on data.
// TESTING
//   Reset: assert reset 2 cycles -> in_ready=1, busy=0, mmu_ctl=0, data_arr=0, wt_arr=0.
//   K=4 tile: beat k = data lanes {4k+0..4k+3}, wt=data+16; in_last on beat 3.
//     -> CLEAR 1 cycle (mmu_clr=1).
//     -> STREAM 7 cycles; at t=3 data lanes = {12,9,6,3}.
//     -> at t=6 lane3=15, lanes0-2=0.
//     -> DRAIN 8 cycles, then done=1 exactly once.
//   K=1 tile, data=0x04030201 -> STREAM 4 cycles; lane i=i+1 only at t=i; done 14 cycles
//     after accept.
//   MAX_K overflow: 16 beats with in_last=0 -> 16th beat accepted, k_len=16, STREAM 19
//     cycles, beat 17 not accepted until LOAD.
//   Backpressure: in_valid held high through whole tile -> no acceptance while busy; next
//     beat accepted the cycle after done.
//   Reset mid-STREAM at t=2 -> next cycle all outputs 0, state LOAD; following K=2 tile
//     streams only new data.

Source files
------------

// File: rtl/mmu_skew_feeder.sv
// mmu_skew_feeder: buffers one tile of K operand beats and replays them diagonally skewed into a
// 4x4 systolic MMU, sequencing accumulator clear, enable, drain and a done pulse.
//   clk, reset            clock; synchronous active-high reset
//   in_valid/in_ready     beat handshake (ready only while idle in LOAD)
//   in_data, in_wt        N lanes of BIT_WIDTH activations / weights, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
//   in_last               final beat of the tile
//   data_arr, wt_arr      skewed operands to the MMU (lane i delayed i cycles)
//   mmu_ctl, mmu_clr      MMU enable and accumulator clear
//   busy, done            not-idle flag; one-cycle tile-finished pulse
//   k_len                 beats in the current tile
module mmu_skew_feeder #(
    parameter int N            = 4,
    parameter int BIT_WIDTH    = 8,
    parameter int MAX_K        = 16,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*BIT_WIDTH-1:0]   in_data,
    input  logic [N*BIT_WIDTH-1:0]   in_wt,
    input  logic                     in_last,
    output logic [N*BIT_WIDTH-1:0]   data_arr,
    output logic [N*BIT_WIDTH-1:0]   wt_arr,
    output logic                     mmu_ctl,
    output logic                     mmu_clr,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(MAX_K):0]   k_len
);
    localparam int KW = $clog2(MAX_K);
    localparam int TW = $clog2(MAX_K + N + DRAIN_CYCLES);
    localparam int W  = N * BIT_WIDTH;

    typedef enum logic [2:0] {LOAD, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_cnt_q, k_cnt_d;
    logic [TW-1:0]   t_cnt_q, t_cnt_d;
    logic [KW:0]     k_len_q, k_len_d;
    logic [W-1:0]    data_buf_q [MAX_K];
    logic [W-1:0]    wt_buf_q   [MAX_K];
    logic [W-1:0]    data_arr_q, data_arr_d, wt_arr_q, wt_arr_d;
    logic            in_ready_q, in_ready_d, mmu_ctl_q, mmu_ctl_d, mmu_clr_q, mmu_clr_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            wr_en;

    assign wr_en = state_q == LOAD && in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        k_cnt_d = k_cnt_q;
        t_cnt_d = t_cnt_q;
        k_len_d = k_len_q;
        case (state_q)
            LOAD: if (wr_en) begin
                k_cnt_d = k_cnt_q + 1'b1;
                // The MAX_K-th beat closes the tile even without in_last.
                if (in_last || k_cnt_q == KW'(MAX_K - 1)) begin
                    k_len_d = {1'b0, k_cnt_q} + 1'b1;
                    k_cnt_d = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                t_cnt_d = '0;
                state_d = STREAM;
            end
            STREAM: if (t_cnt_q == TW'(k_len_q) + TW'(N - 2)) begin
                t_cnt_d = '0;
                state_d = DRAIN;
            end else t_cnt_d = t_cnt_q + 1'b1;
            DRAIN: if (t_cnt_q == TW'(DRAIN_CYCLES - 1)) begin
                t_cnt_d = '0;
                state_d = DONE;
            end else t_cnt_d = t_cnt_q + 1'b1;
            DONE:    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Outputs are decoded from the next state so they land in the same cycle as the state flop.
    always_comb begin
        in_ready_d = state_d == LOAD;
        busy_d     = state_d != LOAD;
        mmu_clr_d  = state_d == CLEAR;
        mmu_ctl_d  = state_d == STREAM || state_d == DRAIN;
        done_d     = state_d == DONE;
        data_arr_d = '0;
        wt_arr_d   = '0;
        // t_cnt-i wraps to a value above any k_len when t_cnt<i, so one unsigned compare bounds both sides.
        for (int i = 0; i < N; i++)
            if (state_d == STREAM && t_cnt_d - TW'(i) < TW'(k_len_q)) begin
                data_arr_d[i*BIT_WIDTH +: BIT_WIDTH] = data_buf_q[KW'(t_cnt_d - TW'(i))][i*BIT_WIDTH +: BIT_WIDTH];
                wt_arr_d[i*BIT_WIDTH +: BIT_WIDTH]   = wt_buf_q[KW'(t_cnt_d - TW'(i))][i*BIT_WIDTH +: BIT_WIDTH];
            end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_buf_q[k_cnt_q] <= in_data;
            wt_buf_q[k_cnt_q]   <= in_wt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            k_cnt_q    <= '0;
            t_cnt_q    <= '0;
            k_len_q    <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            mmu_clr_q  <= 1'b0;
            mmu_ctl_q  <= 1'b0;
            done_q     <= 1'b0;
            data_arr_q <= '0;
            wt_arr_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_cnt_q    <= k_cnt_d;
            t_cnt_q    <= t_cnt_d;
            k_len_q    <= k_len_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            mmu_clr_q  <= mmu_clr_d;
            mmu_ctl_q  <= mmu_ctl_d;
            done_q     <= done_d;
            data_arr_q <= data_arr_d;
            wt_arr_q   <= wt_arr_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign mmu_clr  = mmu_clr_q;
    assign mmu_ctl  = mmu_ctl_q;
    assign done     = done_q;
    assign data_arr = data_arr_q;
    assign wt_arr   = wt_arr_q;
    assign k_len    = k_len_q;
endmodule

// File: tb/tb_mmu_skew_feeder.sv
// tb_mmu_skew_feeder: directed bench for mmu_skew_feeder with hand-derived skew expectations.
module tb_mmu_skew_feeder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] in_wt = '0;
    logic        in_last = 1'b0;
    logic [31:0] data_arr, wt_arr;
    logic        mmu_ctl, mmu_clr, busy, done;
    logic [4:0]  k_len;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    mmu_skew_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_wt(in_wt), .in_last(in_last),
        .data_arr(data_arr), .wt_arr(wt_arr), .mmu_ctl(mmu_ctl), .mmu_clr(mmu_clr),
        .busy(busy), .done(done), .k_len(k_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Beat j, lane i carries base+4j+i.
    function automatic logic [31:0] pat(input int base, input int j);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(base + 4*j + i);
        return r;
    endfunction

    // Lane i at stream step t shows beat t-i when that beat exists, else zero.
    function automatic logic [31:0] exp_skew(input int k, input int base, input int t);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (t - i >= 0 && t - i < k) r[i*8 +: 8] = 8'(base + 4*(t - i) + i);
        return r;
    endfunction

    task automatic load_tile(input int k, input int base, input bit last);
        for (int j = 0; j < k; j++) begin
            in_valid = 1'b1;
            in_data  = pat(base, j);
            in_wt    = pat(base + 16, j);
            in_last  = last && j == k - 1;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Entered with the DUT sampled in CLEAR (the cycle after the closing beat was accepted).
    task automatic stream_check(input int k, input int base);
        int c0;
        c0 = cyc;
        chk("clr", mmu_clr, 1);
        chk("clr_ctl", mmu_ctl, 0);
        chk("clr_ready", in_ready, 0);
        chk("clr_busy", busy, 1);
        chk("k_len", k_len, k);
        chk("clr_data", data_arr, 0);
        for (int t = 0; t < k + 3; t++) begin
            step();
            chk($sformatf("str_data_k%0d_t%0d", k, t), data_arr, exp_skew(k, base, t));
            chk($sformatf("str_wt_k%0d_t%0d", k, t), wt_arr, exp_skew(k, base + 16, t));
            chk("str_ctl", mmu_ctl, 1);
            chk("str_clr", mmu_clr, 0);
            chk("str_no_accept", in_ready, 0);
        end
        for (int d = 0; d < 8; d++) begin
            step();
            chk("drn_ctl", mmu_ctl, 1);
            chk("drn_data", {wt_arr, data_arr}, 0);
            chk("drn_done", done, 0);
            chk("drn_no_accept", in_ready, 0);
        end
        step();
        chk("done", done, 1);
        chk("done_ctl", mmu_ctl, 0);
        chk("done_lat", cyc - c0 + 1, k + 13);
        step();
        chk("done_once", done, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ctl", mmu_ctl, 0);
        chk("rst_clr", mmu_clr, 0);
        chk("rst_done", done, 0);
        chk("rst_arr", {wt_arr, data_arr}, 0);
        reset = 1'b0;

        load_tile(4, 0, 1);
        stream_check(4, 0);
        chk("k4_t3_literal", exp_skew(4, 0, 3), 32'h03_06_09_0C);

        load_tile(1, 1, 1);
        chk("k1_pattern", pat(1, 0), 32'h04030201);
        stream_check(1, 1);

        load_tile(16, 1, 0);
        in_valid = 1'b1;
        in_data  = pat(8'hA0, 0);
        in_wt    = pat(8'hB0, 0);
        in_last  = 1'b1;
        stream_check(16, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        stream_check(1, 8'hA0);

        load_tile(4, 8'h80, 1);
        step();
        step();
        step();
        chk("mid_t2_data", data_arr, exp_skew(4, 8'h80, 2));
        reset = 1'b1;
        step();
        chk("mid_rst_arr", {wt_arr, data_arr}, 0);
        chk("mid_rst_ctl", mmu_ctl, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_klen", k_len, 0);
        reset = 1'b0;
        load_tile(2, 8'h40, 1);
        stream_check(2, 8'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
